fft_radix2_stream: RTL and testbench

Parametrised iterative radix-2 decimation-in-time FFT accelerator with AXI-Stream slave input and AXI-Stream master output, for SIZE = 2, 4 or 8 complex points.
- Buffers one frame from the slave stream, waits for a `start` pulse, and computes in place with one butterfly per cycle.
- Streams the result in natural order on the master stream.
- Generalises the fixed 2-point accelerator to selectable size, complex data, and forward/inverse mode.

---
 rtl/fft_radix2_stream.sv | 204 ++++++++++++++++++++
 tb/tb_fft_radix2_stream.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_radix2_stream.sv
// rtl/fft_radix2_stream.sv - iterative radix-2 DIT FFT, 2/4/8 complex points, AXI-Stream in/out
//
// Ports: s00_axi_aclk/s00_axi_aresetn (clock, async active-low reset);
//        s00_axis_* slave stream (frame load); m00_axis_* master stream (bins out);
//        start/inverse compute request; busy high during COMPUTE and OUTPUT.
// Data word: real in [31:16], imag in [15:0], 16-bit two's complement each.
// Optional macro FFT_SCALE_EN: each butterfly output is halved (floor), scaling the result by 1/SIZE.
module fft_radix2_stream #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    output logic                      s00_axis_tready,
    input  logic [DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                      s00_axis_tlast,
    input  logic                      s00_axis_tvalid,
    output logic                      m00_axis_tvalid,
    output logic [DATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                      m00_axis_tlast,
    input  logic                      m00_axis_tready,
    input  logic                      start,
    input  logic                      inverse,
    output logic                      busy
);
    if (!(SIZE == 2 || SIZE == 4 || SIZE == 8) || DATA_WIDTH != 32) begin : g_bad_param
        $error("fft_radix2_stream: SIZE must be 2, 4 or 8 and DATA_WIDTH must be 32");
    end

    localparam int AW = $clog2(SIZE);
    localparam logic [AW-1:0] LAST_IDX   = AW'(SIZE - 1);
    localparam logic [AW-1:0] LAST_BFLY  = AW'(SIZE / 2 - 1);
    localparam logic [2:0]    LAST_STAGE = 3'(AW - 1);

    typedef enum logic [1:0] {S_LOAD, S_WAIT, S_COMP, S_OUT} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [AW-1:0]         bfly_q, bfly_d;
    logic [2:0]            stage_q, stage_d;
    logic                  inv_q, inv_d;
    logic signed [15:0]    re_q [SIZE];
    logic signed [15:0]    re_d [SIZE];
    logic signed [15:0]    im_q [SIZE];
    logic signed [15:0]    im_d [SIZE];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
        return r;
    endfunction

    // x / sqrt(2) in Q15 with round-half-up before the arithmetic shift
    function automatic logic signed [17:0] mul_rsqrt2(input logic signed [17:0] x);
        logic signed [35:0] p;
        p = 36'(x) * 36'sd23170 + 36'sd16384;
        return 18'(p >>> 15);
    endfunction

    // Butterfly datapath for the current (stage, butterfly) pair
    logic [AW-1:0]      top_a, bot_a;
    logic [1:0]         tw;
    logic signed [17:0] ar, ai, br, bi, wr, wi, sr, si, dr, di;
    logic signed [15:0] top_re, top_im, bot_re, bot_im;

    always_comb begin
        int half, pos, grp, t8;
        half  = 1 << stage_q;
        pos   = int'(bfly_q) & (half - 1);
        grp   = int'(bfly_q) >> stage_q;
        top_a = AW'(grp * 2 * half + pos);
        bot_a = AW'(grp * 2 * half + pos + half);
        // twiddle exponent expressed in eighths of a turn: 0..3 -> 1, (1-j)/r2, -j, (-1-j)/r2
        t8    = (pos << (AW - 1 - int'(stage_q))) << (3 - AW);
        tw    = 2'(t8);
        ar    = 18'(re_q[top_a]);
        ai    = 18'(im_q[top_a]);
        br    = 18'(re_q[bot_a]);
        bi    = 18'(im_q[bot_a]);
        wr    = br;
        wi    = bi;
        case ({inv_q, tw})
            3'b000, 3'b100: begin wr = br;                   wi = bi;                   end
            3'b001:         begin wr = mul_rsqrt2(br + bi);  wi = mul_rsqrt2(bi - br);  end
            3'b010:         begin wr = bi;                   wi = -br;                  end
            3'b011:         begin wr = mul_rsqrt2(bi - br);  wi = mul_rsqrt2(-br - bi); end
            3'b101:         begin wr = mul_rsqrt2(br - bi);  wi = mul_rsqrt2(br + bi);  end
            3'b110:         begin wr = -bi;                  wi = br;                   end
            default:        begin wr = mul_rsqrt2(-br - bi); wi = mul_rsqrt2(br - bi);  end
        endcase
        sr = ar + wr;
        si = ai + wi;
        dr = ar - wr;
        di = ai - wi;
`ifdef FFT_SCALE_EN
        top_re = 16'(sr >>> 1);
        top_im = 16'(si >>> 1);
        bot_re = 16'(dr >>> 1);
        bot_im = 16'(di >>> 1);
`else
        top_re = 16'(sr);
        top_im = 16'(si);
        bot_re = 16'(dr);
        bot_im = 16'(di);
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bfly_d  = bfly_q;
        stage_d = stage_q;
        inv_d   = inv_q;
        re_d    = re_q;
        im_d    = im_q;
        case (state_q)
            S_LOAD: begin
                if (s00_axis_tvalid) begin
                    re_d[bitrev(idx_q)] = s00_axis_tdata[31:16];
                    im_d[bitrev(idx_q)] = s00_axis_tdata[15:0];
                    if (s00_axis_tlast || idx_q == LAST_IDX) begin
                        state_d = S_WAIT;
                        idx_d   = '0;
                        // short frame: everything after the last beat reads as zero
                        for (int i = 0; i < SIZE; i++) begin
                            if (AW'(i) > idx_q) begin
                                re_d[bitrev(AW'(i))] = '0;
                                im_d[bitrev(AW'(i))] = '0;
                            end
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (start) begin
                    inv_d   = inverse;
                    state_d = S_COMP;
                    stage_d = '0;
                    bfly_d  = '0;
                end
            end
            S_COMP: begin
                re_d[top_a] = top_re;
                im_d[top_a] = top_im;
                re_d[bot_a] = bot_re;
                im_d[bot_a] = bot_im;
                if (bfly_q == LAST_BFLY) begin
                    bfly_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        stage_d = '0;
                        state_d = S_OUT;
                    end else begin
                        stage_d = stage_q + 3'd1;
                    end
                end else begin
                    bfly_d = bfly_q + 1'b1;
                end
            end
            S_OUT: begin
                if (m00_axis_tready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            bfly_q  <= '0;
            stage_q <= '0;
            inv_q   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bfly_q  <= bfly_d;
            stage_q <= stage_d;
            inv_q   <= inv_d;
            re_q    <= re_d;
            im_q    <= im_d;
        end
    end

    assign s00_axis_tready = (state_q == S_LOAD);
    assign m00_axis_tvalid = (state_q == S_OUT);
    assign m00_axis_tdata  = (state_q == S_OUT) ? {re_q[idx_q], im_q[idx_q]} : '0;
    assign m00_axis_tlast  = (state_q == S_OUT) && (idx_q == LAST_IDX);
    assign m00_axis_tstrb  = '1;
    assign busy            = (state_q == S_COMP) || (state_q == S_OUT);
endmodule

// File: tb/tb_fft_radix2_stream.sv
// tb/tb_fft_radix2_stream.sv - self-checking bench for fft_radix2_stream (SIZE 2, 4, 8 instances)
module tb_fft_radix2_stream;
    logic        clk;
    logic        rst_n;
    logic        s_tvalid [3];
    logic [31:0] s_tdata  [3];
    logic        s_tlast  [3];
    logic        s_tready [3];
    logic        m_tvalid [3];
    logic [31:0] m_tdata  [3];
    logic [3:0]  m_tstrb  [3];
    logic        m_tlast  [3];
    logic        m_tready [3];
    logic        start_i  [3];
    logic        inv_i    [3];
    logic        busy_o   [3];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [1:0]       dut;
        logic [3:0]       n_in;
        logic             inv;
        logic [1:0]       tol;
        logic [7:0][31:0] din;
        logic [7:0][31:0] dexp;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        tl;
        logic [3:0]  tol;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    fft_radix2_stream #(.SIZE(2)) u_fft2 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axis_tready(s_tready[0]), .s00_axis_tdata(s_tdata[0]), .s00_axis_tlast(s_tlast[0]),
        .s00_axis_tvalid(s_tvalid[0]), .m00_axis_tvalid(m_tvalid[0]), .m00_axis_tdata(m_tdata[0]),
        .m00_axis_tstrb(m_tstrb[0]), .m00_axis_tlast(m_tlast[0]), .m00_axis_tready(m_tready[0]),
        .start(start_i[0]), .inverse(inv_i[0]), .busy(busy_o[0]));
    fft_radix2_stream #(.SIZE(4)) u_fft4 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axis_tready(s_tready[1]), .s00_axis_tdata(s_tdata[1]), .s00_axis_tlast(s_tlast[1]),
        .s00_axis_tvalid(s_tvalid[1]), .m00_axis_tvalid(m_tvalid[1]), .m00_axis_tdata(m_tdata[1]),
        .m00_axis_tstrb(m_tstrb[1]), .m00_axis_tlast(m_tlast[1]), .m00_axis_tready(m_tready[1]),
        .start(start_i[1]), .inverse(inv_i[1]), .busy(busy_o[1]));
    fft_radix2_stream #(.SIZE(8)) u_fft8 (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axis_tready(s_tready[2]), .s00_axis_tdata(s_tdata[2]), .s00_axis_tlast(s_tlast[2]),
        .s00_axis_tvalid(s_tvalid[2]), .m00_axis_tvalid(m_tvalid[2]), .m00_axis_tdata(m_tdata[2]),
        .m00_axis_tstrb(m_tstrb[2]), .m00_axis_tlast(m_tlast[2]), .m00_axis_tready(m_tready[2]),
        .start(start_i[2]), .inverse(inv_i[2]), .busy(busy_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pk(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic logic [31:0] scl(input logic [31:0] x, input int lg);
`ifdef FFT_SCALE_EN
        int re, im;
        re = int'($signed(x[31:16]) >>> lg);
        im = int'($signed(x[15:0]) >>> lg);
        return pk(re, im);
`else
        if (lg < 0) return '0;
        return x;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex, input int tol);
        bit ok;
        int ar, ai, er, ei;
        ar = int'($signed(act[31:16]));
        ai = int'($signed(act[15:0]));
        er = int'($signed(ex[31:16]));
        ei = int'($signed(ex[15:0]));
        n_cmp++;
        if (tol == 0) ok = (act === ex);
        else ok = (ar - er <= tol) && (er - ar <= tol) && (ai - ei <= tol) && (ei - ai <= tol);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h (%0d,%0d) expected %h (%0d,%0d)", nm, act, ar, ai, ex, er, ei);
        end
    endtask

    task automatic load_frame(input vec_t v);
        int d;
        d = int'(v.dut);
        for (int i = 0; i < int'(v.n_in); i++) begin
            @(negedge clk);
            if (i == 0) chk("load_tready", {31'b0, s_tready[d]}, 32'd1, 0);
            s_tvalid[d] = 1'b1;
            s_tdata[d]  = v.din[i];
            s_tlast[d]  = (i == int'(v.n_in) - 1);
            @(posedge clk);
        end
        @(negedge clk);
        s_tvalid[d] = 1'b0;
        s_tlast[d]  = 1'b0;
        s_tdata[d]  = '0;
    endtask

    task automatic run_vec(input vec_t v, input bit bp);
        int d, sz, lg, cnt, beats, j, scale_tol;
        logic [31:0] held_d;
        logic held_l;
        bit stalled;
        exp_t e;
        d  = int'(v.dut);
        sz = 2 << d;
        lg = d + 1;
`ifdef FFT_SCALE_EN
        scale_tol = 1;
`else
        scale_tol = 0;
`endif
        for (int b = 0; b < sz; b++) begin
            e.d   = scl(v.dexp[b], lg);
            e.tl  = (b == sz - 1);
            e.tol = 4'(int'(v.tol) + scale_tol);
            sb.push_back(e);
        end
        load_frame(v);
        start_i[d] = 1'b1;
        inv_i[d]   = v.inv;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            start_i[d] = 1'b0;
            inv_i[d]   = 1'b0;
            if (cnt == 1) chk("busy_rise", {31'b0, busy_o[d]}, 32'd1, 0);
        end while (!m_tvalid[d] && cnt < 100);
        chk("compute_latency", 32'(cnt), 32'((sz / 2) * lg + 1), 0);
        beats = 0;
        j = 0;
        stalled = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        while (beats < sz && j < 200) begin
            m_tready[d] = bp ? ((j % 4 == 0) || (j % 4 == 3)) : 1'b1;
            if (stalled) begin
                chk("hold_tdata", m_tdata[d], held_d, 0);
                chk("hold_tlast", {31'b0, m_tlast[d]}, {31'b0, held_l}, 0);
            end
            if (!m_tvalid[d]) begin
                chk("tvalid_during_output", 32'd0, 32'd1, 0);
            end else if (m_tready[d]) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 32'd1, 32'd0, 0);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("bin%0d_size%0d", beats, sz), m_tdata[d], e.d, int'(e.tol));
                    chk($sformatf("tlast%0d_size%0d", beats, sz), {31'b0, m_tlast[d]}, {31'b0, e.tl}, 0);
                end
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held_d  = m_tdata[d];
                held_l  = m_tlast[d];
            end
            j++;
            @(posedge clk);
            @(negedge clk);
        end
        m_tready[d] = 1'b1;
        if (beats < sz) begin
            chk("drain_timeout", 32'(beats), 32'(sz), 0);
            sb.delete();
        end
        chk("busy_fall", {31'b0, busy_o[d]}, 32'd0, 0);
        chk("tvalid_after", {31'b0, m_tvalid[d]}, 32'd0, 0);
        chk("tready_after", {31'b0, s_tready[d]}, 32'd1, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            s_tvalid[i] = 1'b0; s_tdata[i] = '0; s_tlast[i] = 1'b0;
            m_tready[i] = 1'b1; start_i[i] = 1'b0; inv_i[i] = 1'b0;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].dut = 2'd0; vecs[0].n_in = 4'd2;
        vecs[0].din[0] = pk(3, 0); vecs[0].din[1] = pk(1, 0);
        vecs[0].dexp[0] = pk(4, 0); vecs[0].dexp[1] = pk(2, 0);
        vecs[1].dut = 2'd1; vecs[1].n_in = 4'd4;
        vecs[1].din[0] = pk(100, 0);
        for (int b = 0; b < 4; b++) vecs[1].dexp[b] = pk(100, 0);
        vecs[2].dut = 2'd1; vecs[2].n_in = 4'd4;
        for (int b = 0; b < 4; b++) vecs[2].din[b] = pk(1, 0);
        vecs[2].dexp[0] = pk(4, 0);
        vecs[3].dut = 2'd2; vecs[3].n_in = 4'd8; vecs[3].tol = 2'd1;
        vecs[3].din[1] = pk(1000, 0);
        vecs[3].dexp[0] = pk(1000, 0);  vecs[3].dexp[1] = pk(707, -707);
        vecs[3].dexp[2] = pk(0, -1000); vecs[3].dexp[3] = pk(-707, -707);
        vecs[3].dexp[4] = pk(-1000, 0); vecs[3].dexp[5] = pk(-707, 707);
        vecs[3].dexp[6] = pk(0, 1000);  vecs[3].dexp[7] = pk(707, 707);
        vecs[4] = vecs[3];
        vecs[4].inv = 1'b1;
        vecs[4].dexp[1] = pk(707, 707);   vecs[4].dexp[2] = pk(0, 1000);
        vecs[4].dexp[3] = pk(-707, 707);  vecs[4].dexp[5] = pk(-707, -707);
        vecs[4].dexp[6] = pk(0, -1000);   vecs[4].dexp[7] = pk(707, -707);
        vecs[5].dut = 2'd1; vecs[5].n_in = 4'd2;
        vecs[5].din[0] = pk(5, 0); vecs[5].din[1] = pk(5, 0);
        vecs[5].dexp[0] = pk(10, 0); vecs[5].dexp[1] = pk(5, -5);
        vecs[5].dexp[2] = pk(0, 0);  vecs[5].dexp[3] = pk(5, 5);

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_s_tready", {31'b0, s_tready[d]}, 32'd1, 0);
            chk("rst_m_tvalid", {31'b0, m_tvalid[d]}, 32'd0, 0);
            chk("rst_m_tdata", m_tdata[d], 32'd0, 0);
            chk("rst_m_tlast", {31'b0, m_tlast[d]}, 32'd0, 0);
            chk("rst_m_tstrb", {28'b0, m_tstrb[d]}, 32'hf, 0);
            chk("rst_busy", {31'b0, busy_o[d]}, 32'd0, 0);
        end

        // start while still loading must be ignored
        start_i[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[1] = 1'b0;
        chk("start_in_load_ignored", {31'b0, busy_o[1]}, 32'd0, 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0);

        // output backpressure on the 4-point instance
        run_vec(vecs[1], 1'b1);

        // asynchronous reset in the third compute cycle of the 8-point instance
        load_frame(vecs[3]);
        start_i[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i[2] = 1'b0;
        chk("busy_before_reset", {31'b0, busy_o[2]}, 32'd1, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", {31'b0, m_tvalid[2]}, 32'd0, 0);
        chk("midrst_tready", {31'b0, s_tready[2]}, 32'd1, 0);
        chk("midrst_busy", {31'b0, busy_o[2]}, 32'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[3], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
